// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands with sign correction).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] dsr;
  logic             dbz_r;

  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] ld_d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  assign busy = (state != IDLE);

  // Operand values loaded on accept; a zero divisor keeps the raw dividend in Q
  // so it can be returned as the remainder without a separate register.
  always_comb begin
`ifdef DIV_SIGNED_EN
    ld_d = divisor[WIDTH-1] ? -divisor : divisor;
    if (divisor == '0)
      ld_q = dividend;
    else
      ld_q = dividend[WIDTH-1] ? -dividend : dividend;
`else
    ld_q = dividend;
    ld_d = divisor;
`endif
  end

  // One restoring step: shift the next dividend bit into R, subtract if it fits.
  always_comb begin
    r_sh = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    q_nx = {q_reg[WIDTH-2:0], 1'b0};
    r_nx = r_sh;
    if (r_sh >= {1'b0, dsr}) begin
      r_nx    = r_sh - {1'b0, dsr};
      q_nx[0] = 1'b1;
    end
  end

  // Final results presented while in DONE, including sign correction when enabled.
  always_comb begin
    if (dbz_r) begin
      q_fin = '1;
      r_fin = q_reg;
    end else begin
      q_fin = q_reg;
      r_fin = r_reg[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
      if (neg_q) q_fin = -q_reg;
      if (neg_r) r_fin = -r_reg[WIDTH-1:0];
`endif
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dsr         <= '0;
      dbz_r       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg       <= ld_q;
            dsr         <= ld_d;
            r_reg       <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            dbz_r       <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`endif
            state       <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          q_reg <= q_nx;
          r_reg <= r_nx;
          if (count == LAST) begin
            count <= '0;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= dbz_r;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed steps plus randomized operations
// against an arithmetic reference model. Honours DIV_SIGNED_EN when defined.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones / dividend / flag.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                       output int lat, output logic [W-1:0] q_acc, output logic z_acc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    q_acc = quotient;
    z_acc = div_by_zero;
    lat   = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r, eq, er, qa;
    logic         z, ez, za;
    int           lat;
    do_op(a, b, q, r, z, lat, qa, za);
    model(a, b, eq, er, ez);
    check({tag, "_lat"}, lat, (b == '0) ? 1 : W + 1);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dbz"}, z, ez);
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er, qa;
    logic         z, ez, za;
    int           lat;
    int           seen;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // 15 / 4, then the done pulse must be a single cycle and busy must have dropped
    check_op("t1", 4'b1111, 4'b0100);
    model(4'b1111, 4'b0100, eq, er, ez);
    @(negedge clk);
    check("t1_done_width", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_q_held", quotient, eq);

    // divide by zero, then the flag clears on the next accept while quotient holds
    check_op("t2", 4'b1001, 4'b0000);
    do_op(4'b1111, 4'b0100, q, r, z, lat, qa, za);
    check("t2_dbz_clear_on_accept", za, 0);
    check("t2_q_held_during_op", qa, 4'b1111);

    // exhaustive sweep issued back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b), q, r, z, lat, qa, za);
        model(W'(a), W'(b), eq, er, ez);
        check("sweep_lat", lat, (b == 0) ? 1 : W + 1);
        check("sweep_q", q, eq);
        check("sweep_r", r, er);
        check("sweep_dbz", z, ez);
`ifndef DIV_SIGNED_EN
        if (b != 0) begin
          check("sweep_identity", 32'(q) * 32'(b) + 32'(r), a);
          check("sweep_r_lt_d", (32'(r) < 32'(b)) ? 1 : 0, 1);
        end
`endif
      end
    end

    // randomized operations with random idle gaps
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_op("rand", W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    // second start in the 2nd CALC cycle must be ignored
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd3; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      check("t4_busy_in_flight", busy, 1);
      @(negedge clk);
      lat++;
    end
    model(4'd12, 4'd5, eq, er, ez);
    check("t4_lat", lat, W + 1);
    check("t4_q", quotient, eq);
    check("t4_r", remainder, er);
    @(negedge clk);
    check("t4_no_queued_op", busy, 0);

    // reset during the 3rd CALC cycle aborts the operation
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_q", quotient, 0);
    check("t5_r", remainder, 0);
    check("t5_dbz", div_by_zero, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("t5_no_done_after_abort", seen, 0);
    check_op("t5_fresh", 4'd13, 4'd3);

`ifdef DIV_SIGNED_EN
    @(negedge clk);
    do_op(4'b1001, 4'b0010, q, r, z, lat, qa, za);
    check("t6a_q", q, 4'b1101);
    check("t6a_r", r, 4'b1111);
    do_op(4'b0111, 4'b1110, q, r, z, lat, qa, za);
    check("t6b_q", q, 4'b1101);
    check("t6b_r", r, 4'b0001);
    do_op(4'b1000, 4'b1111, q, r, z, lat, qa, za);
    check("t6c_q", q, 4'b1000);
    check("t6c_r", r, 4'b0000);
    check("t6c_dbz", z, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
